// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per clock.
// Optional macro SEQ_MULT_SIGNED_EN enables two's-complement operands via iSigned.
//
// state | meaning
// IDLE  | oReady=1, waiting for iStart
// BUSY  | one multiplier digit accumulated per cycle
module seq_multiplier #(
    parameter int A_WIDTH        = 16,
    parameter int B_WIDTH        = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                       iClk,
    input  logic                       iRstN,
    input  logic                       iStart,
    input  logic [A_WIDTH-1:0]         iA,
    input  logic [B_WIDTH-1:0]         iB,
    input  logic                       iSigned,
    output logic [A_WIDTH+B_WIDTH-1:0] oRes,
    output logic                       oReady,
    output logic                       oBusy,
    output logic                       oDone
);

    localparam int R_WIDTH = A_WIDTH + B_WIDTH;
    localparam int ACC_W   = R_WIDTH + BITS_PER_CYCLE;
    localparam int N_CYC   = B_WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W   = (N_CYC > 1) ? $clog2(N_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_CYC - 1);

    if (A_WIDTH < 2 || B_WIDTH < 2) begin : gBadWidth
        $error("seq_multiplier: A_WIDTH and B_WIDTH must be >= 2");
    end
    if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) begin : gBadBpc
        $error("seq_multiplier: BITS_PER_CYCLE must be 1, 2 or 4");
    end else if ((B_WIDTH % BITS_PER_CYCLE) != 0) begin : gBadDiv
        $error("seq_multiplier: BITS_PER_CYCLE must divide B_WIDTH");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             stateQ, stateD;
    logic [ACC_W-1:0]   accQ;
    logic [ACC_W-1:0]   mcandQ;
    logic [B_WIDTH-1:0] bQ;
    logic [CNT_W-1:0]   cntQ;
    logic [ACC_W-1:0]   aExt;
    logic [ACC_W-1:0]   partial;
    logic [ACC_W-1:0]   accSum;
    logic               accept;
    logic               lastDigit;

    assign accept    = (stateQ == IDLE) && iStart;
    assign lastDigit = (stateQ == BUSY) && (cntQ == LAST_CNT);
    assign accSum    = accQ + partial;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) stateQ <= IDLE;
        else        stateQ <= stateD;
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (iStart)    stateD = BUSY;
            BUSY:    if (lastDigit) stateD = IDLE;
            default:                stateD = IDLE;
        endcase
    end

    always_comb begin
        oReady = 1'b0;
        oBusy  = 1'b0;
        if (stateQ == IDLE) oReady = 1'b1;
        else                oBusy  = 1'b1;
    end

`ifdef SEQ_MULT_SIGNED_EN
    logic signedQ;

    assign aExt = iSigned ? {{(ACC_W-A_WIDTH){iA[A_WIDTH-1]}}, iA}
                          : {{(ACC_W-A_WIDTH){1'b0}}, iA};

    // The top multiplier bit carries negative weight in signed mode.
    always_comb begin
        partial = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (bQ[j]) begin
                if (signedQ && (cntQ == LAST_CNT) && (j == BITS_PER_CYCLE - 1))
                    partial = partial - (mcandQ << j);
                else
                    partial = partial + (mcandQ << j);
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN)      signedQ <= 1'b0;
        else if (accept) signedQ <= iSigned;
    end
`else
    logic unusedSigned;
    assign unusedSigned = iSigned;

    assign aExt = {{(ACC_W-A_WIDTH){1'b0}}, iA};

    always_comb begin
        partial = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (bQ[j]) partial = partial + (mcandQ << j);
        end
    end
`endif

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            accQ   <= '0;
            mcandQ <= '0;
            bQ     <= '0;
            cntQ   <= '0;
            oRes   <= '0;
            oDone  <= 1'b0;
        end else begin
            oDone <= 1'b0;
            if (accept) begin
                accQ   <= '0;
                mcandQ <= aExt;
                bQ     <= iB;
                cntQ   <= '0;
            end else if (stateQ == BUSY) begin
                accQ   <= accSum;
                mcandQ <= mcandQ << BITS_PER_CYCLE;
                bQ     <= bQ >> BITS_PER_CYCLE;
                cntQ   <= cntQ + CNT_W'(1);
                if (lastDigit) begin
                    oRes  <= accSum[R_WIDTH-1:0];
                    oDone <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: one 1-bit/cycle and one 4-bit/cycle multiplier against a
// plain-arithmetic product model; signed results depend on SEQ_MULT_SIGNED_EN.
module tb_seq_multiplier;

    logic        iClk;
    logic        iRstN;
    logic        start1, start4;
    logic [15:0] iA, iB;
    logic        iSigned;
    logic [31:0] res1, res4;
    logic        ready1, busy1, done1;
    logic        ready4, busy4, done4;

    int checks = 0;
    int passes = 0;

    seq_multiplier #(.A_WIDTH(16), .B_WIDTH(16), .BITS_PER_CYCLE(1)) dut1 (
        .iClk(iClk), .iRstN(iRstN), .iStart(start1), .iA(iA), .iB(iB),
        .iSigned(iSigned), .oRes(res1), .oReady(ready1), .oBusy(busy1), .oDone(done1)
    );

    seq_multiplier #(.A_WIDTH(16), .B_WIDTH(16), .BITS_PER_CYCLE(4)) dut4 (
        .iClk(iClk), .iRstN(iRstN), .iStart(start4), .iA(iA), .iB(iB),
        .iSigned(iSigned), .oRes(res4), .oReady(ready4), .oBusy(busy4), .oDone(done4)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
        longint sa, sb, p;
        bit sg;
        sg = s;
`ifndef SEQ_MULT_SIGNED_EN
        sg = 1'b0;
`endif
        if (sg) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = a;
            sb = b;
        end
        p = sa * sb;
        return p[31:0];
    endfunction

    function automatic logic [31:0] curRes(input bit four);
        return four ? res4 : res1;
    endfunction
    function automatic logic curReady(input bit four);
        return four ? ready4 : ready1;
    endfunction
    function automatic logic curBusy(input bit four);
        return four ? busy4 : busy1;
    endfunction
    function automatic logic curDone(input bit four);
        return four ? done4 : done1;
    endfunction

    task automatic doOp(input bit four, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [31:0] exp, input bit scramble,
                        input string tag);
        int          cyc;
        int          lat;
        bit          seen;
        logic [31:0] prevRes;
        lat = four ? 4 : 16;
        @(negedge iClk);
        iA = a; iB = b; iSigned = s;
        prevRes = curRes(four);
        if (four) start4 = 1'b1; else start1 = 1'b1;
        @(posedge iClk); #1;
        start1 = 1'b0; start4 = 1'b0;
        checks++;
        if (curBusy(four) !== 1'b1 || curReady(four) !== 1'b0)
            $display("FAIL %s accept: busy=%b ready=%b, required busy=1 ready=0",
                     tag, curBusy(four), curReady(four));
        else passes++;
        checks++;
        if (curRes(four) !== prevRes)
            $display("FAIL %s res_hold: got %h, required %h", tag, curRes(four), prevRes);
        else passes++;
        if (scramble) begin
            iA = 16'($urandom); iB = 16'($urandom); iSigned = 1'($urandom);
        end
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(posedge iClk); #1;
            cyc++;
            if (curDone(four)) seen = 1;
            if (scramble) begin
                if (cyc == 1) begin if (four) start4 = 1'b1; else start1 = 1'b1; end
                if (cyc == 2) begin start1 = 1'b0; start4 = 1'b0; end
            end
        end
        start1 = 1'b0; start4 = 1'b0;
        checks++;
        if (!seen || cyc != lat)
            $display("FAIL %s latency: got %0d cycles (done seen=%0d), required %0d",
                     tag, cyc, seen, lat);
        else passes++;
        checks++;
        if (curRes(four) !== exp)
            $display("FAIL %s result: got %h, required %h", tag, curRes(four), exp);
        else passes++;
        checks++;
        if (curReady(four) !== 1'b1 || curBusy(four) !== 1'b0)
            $display("FAIL %s done_ready: ready=%b busy=%b, required ready=1 busy=0",
                     tag, curReady(four), curBusy(four));
        else passes++;
        @(posedge iClk); #1;
        checks++;
        if (curDone(four) !== 1'b0 || curRes(four) !== exp)
            $display("FAIL %s after_done: done=%b res=%h, required done=0 res=%h",
                     tag, curDone(four), curRes(four), exp);
        else passes++;
    endtask

    task automatic test_reset;
        iRstN = 1'b0; start1 = 1'b0; start4 = 1'b0;
        iA = '0; iB = '0; iSigned = 1'b0;
        #1;
        checks++;
        if (res1 !== 32'h0 || ready1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0)
            $display("FAIL reset_dut1: res=%h ready=%b busy=%b done=%b, required 0/1/0/0",
                     res1, ready1, busy1, done1);
        else passes++;
        checks++;
        if (res4 !== 32'h0 || ready4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0)
            $display("FAIL reset_dut4: res=%h ready=%b busy=%b done=%b, required 0/1/0/0",
                     res4, ready4, busy4, done4);
        else passes++;
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iRstN = 1'b1;
        @(posedge iClk); #1;
        checks++;
        if (ready1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0)
            $display("FAIL reset_release: ready=%b busy=%b done=%b, required 1/0/0",
                     ready1, busy1, done1);
        else passes++;
    endtask

    task automatic test_unsigned;
        doOp(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b0, "unsigned_max_b1");
        doOp(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b0, "unsigned_max_b4");
        doOp(1'b0, 16'h0000, 16'hBEEF, 1'b0, 32'h00000000, 1'b0, "unsigned_zero");
    endtask

    task automatic test_signed;
`ifdef SEQ_MULT_SIGNED_EN
        doOp(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1'b0, "signed_m1m1");
        doOp(1'b0, 16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b0, "signed_minmin");
        doOp(1'b0, 16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, 1'b0, "signed_min_one");
`else
        doOp(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001, 1'b0, "signed_ignored");
        doOp(1'b0, 16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b0, "signed_ignored_min");
        doOp(1'b0, 16'h8000, 16'h0001, 1'b1, 32'h00008000, 1'b0, "signed_ignored_one");
`endif
    endtask

    task automatic test_four;
        doOp(1'b1, 16'h1234, 16'h5678, 1'b0, 32'h06260060, 1'b0, "b4_unsigned");
`ifdef SEQ_MULT_SIGNED_EN
        doOp(1'b1, 16'hFFFE, 16'h0003, 1'b1, 32'hFFFFFFFA, 1'b0, "b4_signed");
`else
        doOp(1'b1, 16'hFFFE, 16'h0003, 1'b1, 32'h0002FFFA, 1'b0, "b4_signed_ignored");
`endif
    endtask

    task automatic test_random;
        logic [15:0] a, b;
        logic        s;
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
            doOp(1'b0, a, b, s, model(a, b, s), 1'b1, "random_b1");
            a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
            doOp(1'b1, a, b, s, model(a, b, s), 1'b1, "random_b4");
        end
    endtask

    task automatic test_back_to_back;
        int          doneAt[$];
        bit          prevDone;
        bit          seen;
        logic [31:0] exp;
        exp = model(16'h00C3, 16'h0A05, 1'b0);
        @(negedge iClk);
        iA = 16'h00C3; iB = 16'h0A05; iSigned = 1'b0;
        start1 = 1'b1;
        prevDone = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge iClk); #1;
            if (done1) begin
                doneAt.push_back(c);
                checks++;
                if (prevDone || res1 !== exp)
                    $display("FAIL b2b_pulse: cycle %0d prevDone=%b res=%h, required prevDone=0 res=%h",
                             c, prevDone, res1, exp);
                else passes++;
            end
            if (c == 18) begin
                checks++;
                if (busy1 !== 1'b1)
                    $display("FAIL b2b_reaccept: busy=%b, required 1", busy1);
                else passes++;
            end
            prevDone = done1;
        end
        start1 = 1'b0;
        checks++;
        if (doneAt.size() != 3 || doneAt[0] != 17 || doneAt[1] != 34 || doneAt[2] != 51)
            $display("FAIL b2b_spacing: %0d pulses, first at %0d/%0d/%0d, required 3 at 17/34/51",
                     doneAt.size(), doneAt[0], doneAt[1], doneAt[2]);
        else passes++;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge iClk); #1;
            if (done1) seen = 1;
        end
        checks++;
        if (!seen || res1 !== exp)
            $display("FAIL b2b_drain: done seen=%0d res=%h, required 1 and %h", seen, res1, exp);
        else passes++;
        @(posedge iClk); #1;
    endtask

    task automatic test_reset_mid;
        bit sawDone;
        @(negedge iClk);
        iA = 16'h0007; iB = 16'h0009; iSigned = 1'b0;
        start1 = 1'b1;
        @(posedge iClk); #1;
        start1 = 1'b0;
        repeat (5) @(posedge iClk);
        #2;
        iRstN = 1'b0;
        #1;
        checks++;
        if (res1 !== 32'h0 || ready1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0)
            $display("FAIL mid_reset_dut1: res=%h ready=%b busy=%b done=%b, required 0/1/0/0",
                     res1, ready1, busy1, done1);
        else passes++;
        checks++;
        if (res4 !== 32'h0 || ready4 !== 1'b1)
            $display("FAIL mid_reset_dut4: res=%h ready=%b, required 0/1", res4, ready4);
        else passes++;
        @(posedge iClk);
        @(negedge iClk);
        iRstN = 1'b1;
        sawDone = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge iClk); #1;
            if (done1 || busy1) sawDone = 1;
        end
        checks++;
        if (sawDone)
            $display("FAIL mid_reset_no_done: activity seen=%0d, required 0", sawDone);
        else passes++;
        doOp(1'b0, 16'd3, 16'd5, 1'b0, 32'd15, 1'b0, "after_reset_3x5");
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_four();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
